// File: rtl/vnu_ppl.sv
`default_nettype none
// ============================================================================
//  Module      : vnu_ppl
//  Description : Two-stage pipelined LDPC variable-node update. Stage 1 sums
//                the channel LLR with all incoming check-to-variable messages.
//                Stage 2 forms each outgoing variable-to-check message as
//                (total - own input), clamped symmetrically, plus the hard
//                decision. Valid/ready handshake on both sides, with a
//                16-bit saturating counter of clamp events.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1           clock, rising edge
//    rst        in   1           asynchronous active-high reset
//    llr        in   data_w      channel LLR, signed
//    r          in   data_w*DV   check-to-variable messages, edge j at
//                                [j*data_w +: data_w], signed
//    init       in   1           first iteration: r treated as zero
//    in_valid   in   1           llr/r/init valid
//    in_ready   out  1           input accepted this cycle when valid
//    q          out  data_w*DV   variable-to-check messages, same packing
//    hd         out  1           hard decision (1 = total negative)
//    out_valid  out  1           q/hd valid
//    out_ready  in   1           downstream accepts q/hd
//    clr        in   1           synchronous clear of sat_cnt
//    sat_cnt    out  16          saturating count of clamped messages
// ============================================================================
module vnu_ppl #(
  parameter int data_w = 8,
  parameter int DV     = 3,
  parameter int sum_w  = data_w + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_w-1:0]    llr,
  input  logic [data_w*DV-1:0] r,
  input  logic                 init,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [data_w*DV-1:0] q,
  output logic                 hd,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clr,
  output logic [15:0]          sat_cnt
);

  localparam int CNT_W = $clog2(DV + 1);

  // Symmetric clamp bounds; the most negative code is never produced.
  localparam logic [sum_w-1:0] SAT_MAX = sum_w'((1 << (data_w - 1)) - 1);
  localparam logic [sum_w-1:0] SAT_MIN = -SAT_MAX;

  function automatic logic [sum_w-1:0] sext(input logic [data_w-1:0] v);
    return {{(sum_w - data_w){v[data_w-1]}}, v};
  endfunction

  logic                       advance;
  logic                       s1_valid_q;
  logic [sum_w-1:0]           s1_total_q, s1_total_d;
  logic [DV-1:0][sum_w-1:0]   s1_r_q, s1_r_d;
  logic                       out_valid_q;
  logic [data_w*DV-1:0]       q_q, q_d;
  logic                       hd_q, hd_d;
  logic [CNT_W-1:0]           nclamp_d;
  logic [sum_w-1:0]           diff;
  logic [16:0]                sat_sum;
  logic [15:0]                sat_cnt_q, sat_cnt_d;

  // Only a valid word waiting at the output with no taker blocks the pipe;
  // an empty output stage always lets both stages move.
  assign advance   = !(out_valid_q && !out_ready);
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign hd        = hd_q;
  assign sat_cnt   = sat_cnt_q;

  // Stage 1: sign-extend and accumulate. Inputs are used as-is, including
  // the most negative code.
  always_comb begin
    s1_total_d = sext(llr);
    s1_r_d     = '0;
    for (int j = 0; j < DV; j++) begin
      if (!init) begin
        s1_r_d[j] = sext(r[j*data_w +: data_w]);
      end
      s1_total_d = s1_total_d + s1_r_d[j];
    end
  end

  // Stage 2: extrinsic message per edge with symmetric clamp. sum_w is wide
  // enough that (total - r_j) never wraps for legal DV.
  always_comb begin
    q_d      = '0;
    nclamp_d = '0;
    diff     = '0;
    for (int j = 0; j < DV; j++) begin
      diff = s1_total_q - s1_r_q[j];
      if ($signed(diff) > $signed(SAT_MAX)) begin
        q_d[j*data_w +: data_w] = SAT_MAX[data_w-1:0];
        nclamp_d                = nclamp_d + CNT_W'(1);
      end else if ($signed(diff) < $signed(SAT_MIN)) begin
        q_d[j*data_w +: data_w] = SAT_MIN[data_w-1:0];
        nclamp_d                = nclamp_d + CNT_W'(1);
      end else begin
        q_d[j*data_w +: data_w] = diff[data_w-1:0];
      end
    end
    hd_d = s1_total_q[sum_w-1];
  end

  // Clamp events count only when a valid word actually enters stage 2;
  // the extra carry bit detects overflow so the counter sticks at all-ones.
  always_comb begin
    sat_sum = {1'b0, sat_cnt_q} + 17'(nclamp_d);
    if (clr) begin
      sat_cnt_d = '0;
    end else if (advance && s1_valid_q) begin
      sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_total_q  <= '0;
      s1_r_q      <= '0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      hd_q        <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
      if (advance) begin
        s1_valid_q  <= in_valid;
        out_valid_q <= s1_valid_q;
        if (in_valid) begin
          s1_total_q <= s1_total_d;
          s1_r_q     <= s1_r_d;
        end
        if (s1_valid_q) begin
          q_q  <= q_d;
          hd_q <= hd_d;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vnu_ppl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vnu_ppl
//  Description : Scoreboard bench for vnu_ppl (data_w=8, DV=3). Directed
//                vectors push hand-computed responses; a monitor pops and
//                compares whenever an output is handed off.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vnu_ppl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  llr = '0;
  logic [23:0] r = '0;
  logic        init = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] q;
  logic        hd;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] sat_cnt;

  typedef struct packed {
    logic [23:0] q;
    logic        hd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   wt;

  vnu_ppl #(.data_w(8), .DV(3), .sum_w(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .llr       (llr),
    .r         (r),
    .init      (init),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .hd        (hd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr       (clr),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pk(input int a, input int b, input int c);
    return {c[7:0], b[7:0], a[7:0]};
  endfunction

  // Present one input and hold it until accepted; optionally record the
  // hand-computed response.
  task automatic send(input int l, input int r0, input int r1, input int r2,
                      input bit ini, input int e0, input int e1, input int e2,
                      input bit ehd, input bit push);
    logic acc;
    int   t;
    exp_t e;
    llr      = l[7:0];
    r        = pk(r0, r1, r2);
    init     = ini;
    in_valid = 1'b1;
    t        = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) break;
      t++;
      if (t > 100) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (push) begin
      e.q  = pk(e0, e1, e2);
      e.hd = ehd;
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every handed-off output against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_output", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("q", {8'd0, q}, {8'd0, e.q});
          chk("hd", {31'd0, hd}, {31'd0, e.hd});
        end
      end
    end
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {8'd0, q}, 32'd0);
    chk("rst_hd", {31'd0, hd}, 32'd0);
    chk("rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic function
    send(10, 99, 99, 99, 1'b1, 10, 10, 10, 1'b0, 1'b1);
    send(-5, 20, -3, 7, 1'b0, -1, 22, 12, 1'b0, 1'b1);
    drain();
    chk("sat_after_basic", {16'd0, sat_cnt}, 32'd0);

    // Saturation in both directions
    send(127, 127, 127, 127, 1'b0, 127, 127, 127, 1'b0, 1'b1);
    send(-100, -100, -100, -100, 1'b0, -127, -127, -127, 1'b1, 1'b1);
    drain();
    chk("sat_after_two", {16'd0, sat_cnt}, 32'd6);

    // Most-negative input code, zero total, exact +127 boundary
    send(-128, -128, -128, -128, 1'b1, -127, -127, -127, 1'b1, 1'b1);
    send(0, 5, -5, 0, 1'b0, -5, 5, 0, 1'b0, 1'b1);
    send(0, -128, 127, 0, 1'b0, 127, -127, -1, 1'b1, 1'b1);
    drain();
    chk("sat_after_bounds", {16'd0, sat_cnt}, 32'd10);

    // Back-to-back A,B,C with the output held off for three cycles
    out_ready = 1'b0;
    fork
      begin
        send(-5, 20, -3, 7, 1'b0, -1, 22, 12, 1'b0, 1'b1);
        send(1, 1, 1, 1, 1'b0, 3, 3, 3, 1'b0, 1'b1);
        send(-3, 50, 50, 50, 1'b1, -3, -3, -3, 1'b1, 1'b1);
      end
      begin
        wt = 0;
        do begin
          @(negedge clk);
          wt++;
        end while (!out_valid && wt < 50);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_q", {8'd0, q}, {8'd0, pk(-1, 22, 12)});
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("sat_after_stall", {16'd0, sat_cnt}, 32'd10);

    // Reset with two items in flight
    send(127, 127, 127, 127, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    send(127, 127, 127, 127, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_q", {8'd0, q}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(3, 0, 0, 0, 1'b1, 3, 3, 3, 1'b0, 1'b1);
    drain();
    chk("sat_after_rst", {16'd0, sat_cnt}, 32'd0);

    // Clear coinciding with a saturating word entering the output stage
    send(127, 127, 127, 127, 1'b0, 127, 127, 127, 1'b0, 1'b1);
    drain();
    chk("sat_before_clr", {16'd0, sat_cnt}, 32'd3);
    send(-100, -100, -100, -100, 1'b0, -127, -127, -127, 1'b1, 1'b1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("sat_clr_edge", {16'd0, sat_cnt}, 32'd0);
    drain();
    chk("sat_after_clr", {16'd0, sat_cnt}, 32'd0);

    // Counter ceiling: 21845 * 3 = 65535 exactly, then one more word
    for (int i = 0; i < 21845; i++) begin
      send(127, 127, 127, 127, 1'b0, 127, 127, 127, 1'b0, 1'b1);
    end
    drain();
    chk("sat_full", {16'd0, sat_cnt}, 32'd65535);
    send(-100, -100, -100, -100, 1'b0, -127, -127, -127, 1'b1, 1'b1);
    drain();
    chk("sat_sticky", {16'd0, sat_cnt}, 32'h0000FFFF);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
